// File: rtl/mem_readout_sequencer_pkg.sv
// Shared definitions for the memory read-out sequencer: state encoding,
// default framing bytes and word geometry.
package mem_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_BYTE = 3'd4,
    ST_NEXT = 3'd5,
    ST_TRL  = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  localparam int         ADDR_W_DEF     = 30;
  localparam int         BYTES_PER_WORD = 4;
  localparam logic [7:0] HDR_BYTE_DEF   = 8'h24;
  localparam logic [7:0] TRL_BYTE_DEF   = 8'h0A;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_readout_sequencer_tx_byte_writer.sv
// Paced writer into the UART TX FIFO. A byte offered with i_valid is taken
// only when the FIFO is not full and no write went out in the current cycle,
// so writes are spaced by at least one idle cycle and the full flag (which
// lags a write by one cycle) is always settled when it is examined.
module tx_byte_writer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  input  logic       i_full,
  output logic       o_accepted,
  output logic [7:0] o_tx_data,
  output logic       o_tx_write
);

  logic       r_tx_write;
  logic [7:0] r_tx_data;
  logic       w_accept;

  assign w_accept   = i_valid & ~i_full & ~r_tx_write;
  assign o_accepted = w_accept;
  assign o_tx_write = r_tx_write;
  assign o_tx_data  = r_tx_data;

  // Register the strobe and byte so the FIFO sees clean one-cycle writes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tx_write <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_write <= w_accept;
      if (w_accept) begin
        r_tx_data <= i_byte;
      end
    end
  end

endmodule

// File: rtl/mem_readout_sequencer.sv
// Memory read-out sequencer: fetches words start..end from acquisition
// memory and streams them LSB-first into the UART TX FIFO, framed by a
// header and trailer byte.
//
// state | meaning
// IDLE  | waiting for start; range check on start
// HDR   | offering the header byte
// REQ   | issuing a read request for addr_cnt
// WAIT  | request outstanding until mem_rd_valid
// BYTE  | offering the low byte of the shift register
// NEXT  | end-of-range compare, else advance address
// TRL   | offering the trailer byte
// DONE  | one-cycle done pulse
module mem_readout_sequencer
  import mem_readout_pkg::*;
#(
  parameter int         ADDR_W   = ADDR_W_DEF,
  parameter int         DATA_W   = 8 * BYTES_PER_WORD,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF,
  parameter logic [7:0] TRL_BYTE = TRL_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_end,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_write,
  input  logic              tx_buffer_full,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BPW    = bytes_per_word(DATA_W);
  localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr_cnt;
  logic [ADDR_W-1:0]   r_addr_end;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_req;
  logic [DATA_W-1:0]   r_shift;
  logic [BCNT_W-1:0]   r_byte_cnt;
  logic                r_error;
  logic                r_rej_done;
  logic                r_abort_pend;

  logic                w_tx_valid;
  logic [7:0]          w_tx_byte;
  logic                w_tx_accepted;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_issue_req;
  logic                w_drop_req;
  logic                w_capture;
  logic                w_byte_adv;
  logic                w_addr_inc;
  logic                w_abort_hit;

  tx_byte_writer u_tx (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_valid    (w_tx_valid),
    .i_byte     (w_tx_byte),
    .i_full     (tx_buffer_full),
    .o_accepted (w_tx_accepted),
    .o_tx_data  (tx_data),
    .o_tx_write (tx_write)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Byte offered to the TX writer; withheld on abort so no data byte slips out.
  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_byte  = '0;
    case (r_state)
      ST_HDR: begin
        w_tx_valid = ~abort;
        w_tx_byte  = HDR_BYTE;
      end
      ST_BYTE: begin
        w_tx_valid = ~abort;
        w_tx_byte  = r_shift[7:0];
      end
      ST_TRL: begin
        w_tx_valid = 1'b1;
        w_tx_byte  = TRL_BYTE;
      end
      default: ;
    endcase
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_issue_req = 1'b0;
    w_drop_req  = 1'b0;
    w_capture   = 1'b0;
    w_byte_adv  = 1'b0;
    w_addr_inc  = 1'b0;
    w_abort_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (addr_end >= addr_start) begin
            w_start_ok  = 1'b1;
            w_state_nxt = ST_HDR;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (abort) begin
          w_abort_hit = 1'b1;
          w_state_nxt = ST_TRL;
        end else if (w_tx_accepted) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (abort) begin
          w_abort_hit = 1'b1;
          w_state_nxt = ST_TRL;
        end else begin
          w_issue_req = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An outstanding request always completes before abort takes effect.
        if (mem_rd_valid) begin
          w_drop_req = 1'b1;
          if (abort || r_abort_pend) begin
            w_abort_hit = 1'b1;
            w_state_nxt = ST_TRL;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = ST_BYTE;
          end
        end
      end
      ST_BYTE: begin
        if (abort) begin
          w_abort_hit = 1'b1;
          w_state_nxt = ST_TRL;
        end else if (w_tx_accepted) begin
          w_byte_adv = 1'b1;
          if (r_byte_cnt == BCNT_W'(BPW - 1)) begin
            w_state_nxt = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        // Compare before increment so the top address ends without wrapping.
        if (abort) begin
          w_abort_hit = 1'b1;
          w_state_nxt = ST_TRL;
        end else if (r_addr_cnt == r_addr_end) begin
          w_state_nxt = ST_TRL;
        end else begin
          w_addr_inc  = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_TRL: begin
        w_abort_hit = abort;
        if (w_tx_accepted) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address, request, shift register and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr_cnt   <= '0;
      r_addr_end   <= '0;
      r_addr       <= '0;
      r_req        <= 1'b0;
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_error      <= 1'b0;
      r_rej_done   <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_rej_done   <= w_start_bad;
      r_abort_pend <= (r_state == ST_WAIT) && !mem_rd_valid && (abort || r_abort_pend);
      if (w_start_ok) begin
        r_addr_cnt <= addr_start;
        r_addr_end <= addr_end;
        r_error    <= 1'b0;
      end
      if (w_start_bad || w_abort_hit) begin
        r_error <= 1'b1;
      end
      if (w_issue_req) begin
        r_req  <= 1'b1;
        r_addr <= r_addr_cnt;
      end
      if (w_drop_req) begin
        r_req <= 1'b0;
      end
      if (w_capture) begin
        r_shift    <= mem_rd_data;
        r_byte_cnt <= '0;
      end
      if (w_byte_adv) begin
        r_shift    <= r_shift >> 8;
        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
      end
      if (w_addr_inc) begin
        r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
      end
    end
  end

  assign mem_rd_req  = r_req;
  assign mem_rd_addr = r_addr;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done        = (r_state == ST_DONE) || r_rej_done;
  assign error       = r_error;

endmodule

// File: tb/tb_mem_readout_sequencer.sv
// Directed bench for mem_readout_sequencer with a byte/address scoreboard
// and a behavioural memory with programmable latency.
module tb_mem_readout_sequencer;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] addr_start = '0;
  logic [ADDR_W-1:0] addr_end = '0;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_valid = 1'b0;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic [7:0]        tx_data;
  logic              tx_write;
  logic              tx_buffer_full = 1'b0;
  logic              busy;
  logic              done;
  logic              error;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  logic [7:0]        exp_bytes[$];
  logic [ADDR_W-1:0] exp_addrs[$];

  int   wr_cnt = 0;
  int   req_cnt = 0;
  int   done_cnt = 0;
  int   first_wr_cyc = -1;
  logic prev_tx_write = 1'b0;
  logic prev_done = 1'b0;

  bit                mem_pend = 1'b0;
  int                mem_lat_cnt = 0;
  int                mem_lat = 3;
  logic [ADDR_W-1:0] mem_addr_q = '0;
  int                full_cnt = 0;

  always #5 clk = ~clk;

  mem_readout_sequencer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .HDR_BYTE (8'h24),
    .TRL_BYTE (8'h0A)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .addr_start     (addr_start),
    .addr_end       (addr_end),
    .mem_rd_req     (mem_rd_req),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_data    (mem_rd_data),
    .tx_data        (tx_data),
    .tx_write       (tx_write),
    .tx_buffer_full (tx_buffer_full),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [7:0] lo;
    logic [7:0] mid;
    lo  = a[7:0];
    mid = a[15:8];
    if (a == 30'h10) return 32'hDEADBEEF;
    return {lo ^ 8'h3C, ~lo, lo + 8'h11, mid ^ 8'hC3};
  endfunction

  task automatic push_word(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = mem_word(a);
    for (int b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
  endtask

  // One clock: sample outputs 1 time unit after the edge, score them, and
  // advance the memory and full-flag models.
  task automatic tick();
    logic [7:0]        eb;
    logic [ADDR_W-1:0] ea;
    @(posedge clk);
    #1;
    cycle++;
    if (tx_write) begin
      wr_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cycle;
      check("tx_spacing", 64'(prev_tx_write), 64'(0));
      check("tx_while_full", 64'(tx_buffer_full), 64'(0));
      check("tx_expected", 64'(exp_bytes.size() != 0), 64'(1));
      if (exp_bytes.size() != 0) begin
        eb = exp_bytes.pop_front();
        check("tx_byte", 64'(tx_data), 64'(eb));
      end
    end
    prev_tx_write = tx_write;
    if (done) begin
      done_cnt++;
      check("done_width", 64'(prev_done), 64'(0));
    end
    prev_done = done;
    if (mem_rd_valid) begin
      mem_rd_valid = 1'b0;
      mem_pend = 1'b0;
    end else if (mem_pend) begin
      check("req_held", 64'({mem_rd_req, mem_rd_addr}), 64'({1'b1, mem_addr_q}));
      mem_lat_cnt--;
      if (mem_lat_cnt <= 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem_word(mem_addr_q);
      end
    end else if (mem_rd_req) begin
      req_cnt++;
      mem_pend    = 1'b1;
      mem_lat_cnt = mem_lat;
      mem_addr_q  = mem_rd_addr;
      check("req_expected", 64'(exp_addrs.size() != 0), 64'(1));
      if (exp_addrs.size() != 0) begin
        ea = exp_addrs.pop_front();
        check("req_addr", 64'(mem_rd_addr), 64'(ea));
      end
    end
    if (full_cnt > 0) begin
      full_cnt--;
      tx_buffer_full = (full_cnt > 0);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cyc && done_cnt == d0; i++) tick();
  endtask

  initial begin
    int  d0, w0, r0, sc, c_at, nxt_cyc;
    bit  forced, aborted;

    // Reset
    reset_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 64'({mem_rd_req, mem_rd_addr, tx_data, tx_write, busy, done, error}), 64'(0));
    reset_n = 1'b1;
    tick();

    // Single word at 0x10
    d0 = done_cnt; w0 = wr_cnt; r0 = req_cnt; first_wr_cyc = -1; mem_lat = 3;
    addr_start = 30'h10; addr_end = 30'h10;
    exp_bytes.push_back(8'h24); exp_bytes.push_back(8'hEF); exp_bytes.push_back(8'hBE);
    exp_bytes.push_back(8'hAD); exp_bytes.push_back(8'hDE); exp_bytes.push_back(8'h0A);
    exp_addrs.push_back(30'h10);
    start = 1'b1; sc = cycle; tick(); start = 1'b0;
    check("t1_busy", 64'(busy), 64'(1));
    wait_done(200);
    repeat (3) tick();
    check("t1_done", 64'(done_cnt - d0), 64'(1));
    check("t1_hdr_latency", 64'(first_wr_cyc - sc), 64'(2));
    check("t1_bytes", 64'(wr_cnt - w0), 64'(6));
    check("t1_reqs", 64'(req_cnt - r0), 64'(1));
    check("t1_error", 64'(error), 64'(0));
    check("t1_busy_end", 64'(busy), 64'(0));
    check("t1_left", 64'(exp_bytes.size()), 64'(0));

    // Top of address space: no wrap to 0
    d0 = done_cnt; w0 = wr_cnt; r0 = req_cnt; mem_lat = 1;
    addr_start = 30'h3FFFFFFE; addr_end = 30'h3FFFFFFF;
    exp_bytes.push_back(8'h24); push_word(30'h3FFFFFFE); push_word(30'h3FFFFFFF); exp_bytes.push_back(8'h0A);
    exp_addrs.push_back(30'h3FFFFFFE); exp_addrs.push_back(30'h3FFFFFFF);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(400);
    repeat (8) tick();
    check("t2_done", 64'(done_cnt - d0), 64'(1));
    check("t2_bytes", 64'(wr_cnt - w0), 64'(10));
    check("t2_reqs", 64'(req_cnt - r0), 64'(2));
    check("t2_error", 64'(error), 64'(0));
    check("t2_left", 64'(exp_bytes.size() + exp_addrs.size()), 64'(0));

    // Reversed range is rejected
    d0 = done_cnt; w0 = wr_cnt; r0 = req_cnt;
    addr_start = 30'd5; addr_end = 30'd4;
    start = 1'b1; tick(); start = 1'b0;
    check("t3_done_next", 64'(done), 64'(1));
    check("t3_error", 64'(error), 64'(1));
    repeat (10) tick();
    check("t3_done_cnt", 64'(done_cnt - d0), 64'(1));
    check("t3_no_activity", 64'({wr_cnt - w0, req_cnt - r0}), 64'(0));
    check("t3_busy", 64'(busy), 64'(0));

    // Three words with the FIFO full for 20 cycles mid-word
    d0 = done_cnt; w0 = wr_cnt; r0 = req_cnt; mem_lat = 5;
    addr_start = 30'h100; addr_end = 30'h102;
    exp_bytes.push_back(8'h24);
    for (int a = 'h100; a <= 'h102; a++) begin
      push_word(ADDR_W'(a));
      exp_addrs.push_back(ADDR_W'(a));
    end
    exp_bytes.push_back(8'h0A);
    start = 1'b1; tick(); start = 1'b0;
    check("t4_error_cleared", 64'(error), 64'(0));
    forced = 1'b0; c_at = 0; nxt_cyc = -1;
    for (int i = 0; i < 800 && done_cnt == d0; i++) begin
      tick();
      if (forced && nxt_cyc < 0 && wr_cnt - w0 == 4) nxt_cyc = cycle;
      if (!forced && wr_cnt - w0 == 3) begin
        forced = 1'b1; tx_buffer_full = 1'b1; full_cnt = 20; c_at = cycle;
      end
    end
    repeat (3) tick();
    check("t4_full_applied", 64'(forced), 64'(1));
    check("t4_stall_len", 64'(nxt_cyc - c_at >= 21), 64'(1));
    check("t4_done", 64'(done_cnt - d0), 64'(1));
    check("t4_bytes", 64'(wr_cnt - w0), 64'(14));
    check("t4_reqs", 64'(req_cnt - r0), 64'(3));
    check("t4_error", 64'(error), 64'(0));
    check("t4_left", 64'(exp_bytes.size() + exp_addrs.size()), 64'(0));

    // Abort while waiting on word 2 of 4
    d0 = done_cnt; w0 = wr_cnt; r0 = req_cnt; mem_lat = 4;
    addr_start = 30'h200; addr_end = 30'h203;
    exp_bytes.push_back(8'h24); push_word(30'h200); exp_bytes.push_back(8'h0A);
    exp_addrs.push_back(30'h200); exp_addrs.push_back(30'h201);
    start = 1'b1; tick(); start = 1'b0;
    aborted = 1'b0;
    for (int i = 0; i < 500 && done_cnt == d0; i++) begin
      tick();
      if (!aborted && req_cnt - r0 == 2) begin
        abort = 1'b1; aborted = 1'b1;
      end
    end
    abort = 1'b0;
    repeat (8) tick();
    check("t5_abort_applied", 64'(aborted), 64'(1));
    check("t5_done", 64'(done_cnt - d0), 64'(1));
    check("t5_bytes", 64'(wr_cnt - w0), 64'(6));
    check("t5_reqs", 64'(req_cnt - r0), 64'(2));
    check("t5_error", 64'(error), 64'(1));
    check("t5_left", 64'(exp_bytes.size() + exp_addrs.size()), 64'(0));

    // Reset in the middle of a word
    d0 = done_cnt; w0 = wr_cnt; r0 = req_cnt; mem_lat = 2;
    addr_start = 30'h300; addr_end = 30'h301;
    exp_bytes.push_back(8'h24); push_word(30'h300);
    exp_addrs.push_back(30'h300);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 200 && wr_cnt - w0 < 3; i++) tick();
    reset_n = 1'b0;
    tick();
    check("t6_reset_outputs", 64'({mem_rd_req, mem_rd_addr, tx_data, tx_write, busy, done, error}), 64'(0));
    check("t6_unsent", 64'(exp_bytes.size()), 64'(2));
    check("t6_reqs", 64'({req_cnt - r0, exp_addrs.size()}), 64'({32'd1, 32'd0}));
    exp_bytes.delete();
    w0 = wr_cnt;
    reset_n = 1'b1;
    repeat (10) tick();
    check("t6_no_trailer", 64'(wr_cnt - w0), 64'(0));
    check("t6_no_done", 64'(done_cnt - d0), 64'(0));

    // Clean transfer after reset
    d0 = done_cnt; w0 = wr_cnt; r0 = req_cnt; mem_lat = 3;
    addr_start = 30'h10; addr_end = 30'h11;
    exp_bytes.push_back(8'h24); push_word(30'h10); push_word(30'h11); exp_bytes.push_back(8'h0A);
    exp_addrs.push_back(30'h10); exp_addrs.push_back(30'h11);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(400);
    repeat (3) tick();
    check("t7_done", 64'(done_cnt - d0), 64'(1));
    check("t7_bytes", 64'(wr_cnt - w0), 64'(10));
    check("t7_reqs", 64'(req_cnt - r0), 64'(2));
    check("t7_error", 64'(error), 64'(0));
    check("t7_left", 64'(exp_bytes.size() + exp_addrs.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
